floor_goal: RTL and testbench

- Elevator goal-floor register for a 3-floor car.
- Each clock, while the car is stopped, picks a target floor from the floor request lamps (led1..led3) and the current floor, then holds it.
- The held goal feeds the motion/direction controller.
- While the car is moving, or the floor code is invalid, the goal is frozen.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/goal_select.sv | 34 +++
 rtl/floor_goal.sv | 56 +++++
 tb/tb_floor_goal.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator types: floor code typedef and default floor label encodings.
package elevator_pkg;

  localparam int unsigned FLOOR_W = 2;
  localparam int unsigned NUM_FLOORS = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  localparam floor_t LABEL_F1      = 2'b00;
  localparam floor_t LABEL_F2      = 2'b01;
  localparam floor_t LABEL_F3      = 2'b10;
  localparam floor_t FLOOR_INVALID = 2'b11;

endpackage

// File: rtl/goal_select.sv
// Combinational goal chooser: current-floor request first, then nearest lit floor, lower floor on a tie.
module goal_select
  import elevator_pkg::*;
#(
  parameter floor_t labelF1 = LABEL_F1,
  parameter floor_t labelF2 = LABEL_F2,
  parameter floor_t labelF3 = LABEL_F3
) (
  input  logic [FLOOR_W-1:0]    floor,
  input  logic [NUM_FLOORS-1:0] leds,     // {led3, led2, led1}
  output logic [FLOOR_W-1:0]    goal_c,
  output logic                  has_req_c
);

  always_comb begin
    goal_c    = floor;
    has_req_c = |leds;
    if (floor == labelF1) begin
      if      (leds[0]) goal_c = labelF1;
      else if (leds[1]) goal_c = labelF2;
      else if (leds[2]) goal_c = labelF3;
    end else if (floor == labelF2) begin
      // F1 and F3 are equidistant from F2; the lower floor wins
      if      (leds[1]) goal_c = labelF2;
      else if (leds[0]) goal_c = labelF1;
      else if (leds[2]) goal_c = labelF3;
    end else if (floor == labelF3) begin
      if      (leds[2]) goal_c = labelF3;
      else if (leds[1]) goal_c = labelF2;
      else if (leds[0]) goal_c = labelF1;
    end
  end

endmodule

// File: rtl/floor_goal.sv
// Goal-floor register: captures the selected target while the car is stopped on a valid floor.
module floor_goal
  import elevator_pkg::*;
#(
  parameter floor_t labelF1 = LABEL_F1,
  parameter floor_t labelF2 = LABEL_F2,
  parameter floor_t labelF3 = LABEL_F3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOOR_W-1:0] floor,
  input  logic               led1,
  input  logic               led2,
  input  logic               led3,
  input  logic               moving,
  output logic [FLOOR_W-1:0] gf,
  output logic               gf_valid
);

  // Labels must be distinct and must never alias the invalid floor code
  if (labelF1 == labelF2 || labelF1 == labelF3 || labelF2 == labelF3 ||
      labelF1 == FLOOR_INVALID || labelF2 == FLOOR_INVALID ||
      labelF3 == FLOOR_INVALID) begin : g_bad_labels
    $error("floor_goal: floor labels must be distinct and differ from the invalid code");
  end

  logic [FLOOR_W-1:0] goal_c;
  logic               has_req_c;
  logic               floor_ok_c;
  logic               upd_c;

  goal_select #(
    .labelF1 (labelF1),
    .labelF2 (labelF2),
    .labelF3 (labelF3)
  ) u_goal_select (
    .floor     (floor),
    .leds      ({led3, led2, led1}),
    .goal_c    (goal_c),
    .has_req_c (has_req_c)
  );

  assign floor_ok_c = (floor == labelF1) || (floor == labelF2) || (floor == labelF3);
  assign upd_c      = !moving && floor_ok_c && has_req_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      gf       <= labelF1;
      gf_valid <= 1'b0;
    end else if (upd_c) begin
      gf       <= goal_c;
      gf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_floor_goal.sv
// Self-checking bench for floor_goal: directed plan steps plus random traffic against a distance-based model.
module tb_floor_goal;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] floor;
  logic       led1, led2, led3;
  logic       moving;
  logic [1:0] gf;
  logic       gf_valid;

  int checks = 0;
  int errors = 0;

  // Model state: goal held as floor index 1..3
  int  m_goal  = 1;
  bit  m_valid = 1'b0;

  floor_goal dut (
    .clk      (clk),
    .rst      (rst),
    .floor    (floor),
    .led1     (led1),
    .led2     (led2),
    .led3     (led3),
    .moving   (moving),
    .gf       (gf),
    .gf_valid (gf_valid)
  );

  always #5 clk = ~clk;

  function automatic int code_to_idx(input logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] idx_to_code(input int i);
    logic [1:0] c;
    c = 2'(i - 1);
    return c;
  endfunction

  // Reference: requested floor at the car, else nearest lit floor, lower index on a tie
  task automatic model_step(input logic r, input logic [1:0] f, input logic [2:0] l,
                            input logic m);
    int cur;
    int best;
    int best_d;
    int d;
    cur = code_to_idx(f);
    if (r) begin
      m_goal  = 1;
      m_valid = 1'b0;
    end else if (!m && cur != 0 && l != 3'b000) begin
      best   = 0;
      best_d = 99;
      for (int j = 1; j <= 3; j++) begin
        if (l[j-1]) begin
          d = (j > cur) ? j - cur : cur - j;
          if (d < best_d) begin
            best_d = d;
            best   = j;
          end
        end
      end
      m_goal  = best;
      m_valid = 1'b1;
    end
  endtask

  task automatic check(input string tag);
    logic [1:0] exp_gf;
    exp_gf = idx_to_code(m_goal);
    checks++;
    assert (gf === exp_gf)
    else begin
      errors++;
      $error("FAIL %s gf observed=%b expected=%b", tag, gf, exp_gf);
    end
    checks++;
    assert (gf_valid === m_valid)
    else begin
      errors++;
      $error("FAIL %s gf_valid observed=%b expected=%b", tag, gf_valid, m_valid);
    end
  endtask

  // leds argument is {led3, led2, led1}
  task automatic apply(input string tag, input logic r, input logic [1:0] f,
                       input logic [2:0] l, input logic m);
    rst    = r;
    floor  = f;
    led1   = l[0];
    led2   = l[1];
    led3   = l[2];
    moving = m;
    model_step(r, f, l, m);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b1; floor = 2'b00; led1 = 1'b0; led2 = 1'b0; led3 = 1'b0; moving = 1'b0;

    apply("reset",          1'b1, 2'b00, 3'b000, 1'b0);
    apply("hold_no_leds",   1'b0, 2'b00, 3'b000, 1'b0);
    apply("own_floor_f1",   1'b0, 2'b00, 3'b001, 1'b0);
    apply("moving_hold",    1'b0, 2'b01, 3'b011, 1'b1);
    apply("f3_to_f2",       1'b0, 2'b10, 3'b010, 1'b0);
    apply("invalid_hold_a", 1'b0, 2'b11, 3'b001, 1'b0);
    apply("invalid_hold_b", 1'b0, 2'b11, 3'b011, 1'b0);
    apply("f1_to_f3",       1'b0, 2'b00, 3'b100, 1'b0);
    apply("own_floor_f3",   1'b0, 2'b10, 3'b101, 1'b0);
    apply("moving_hold_f3", 1'b0, 2'b10, 3'b011, 1'b1);
    apply("tie_low_wins",   1'b0, 2'b01, 3'b101, 1'b0);
    apply("f1_nearest_f2",  1'b0, 2'b00, 3'b110, 1'b0);
    apply("f3_nearest_f2",  1'b0, 2'b10, 3'b011, 1'b0);
    apply("f3_only_f1",     1'b0, 2'b10, 3'b001, 1'b0);
    apply("no_leds_keep",   1'b0, 2'b01, 3'b000, 1'b0);
    apply("set_goal_f3",    1'b0, 2'b00, 3'b100, 1'b0);
    apply("reset_mid_op",   1'b1, 2'b00, 3'b100, 1'b0);
    apply("after_reset",    1'b0, 2'b11, 3'b000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      apply("random",
            ($urandom_range(0, 19) == 0),
            2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
